// File: rtl/sparc_exu_yctl_pkg.sv
// Shared definitions for the EXU divider Y-register control slice: per-thread
// pending-write state encoding, default strand count and a one-hot checker.
package sparc_exu_yctl_pkg;

  localparam int          NTHR_DEF = 4;

  localparam logic [1:0]  YS_IDLE  = 2'd0;
  localparam logic [1:0]  YS_WRY_P = 2'd1;
  localparam logic [1:0]  YS_MUL_P = 2'd2;

  // Per-thread Y state: idle, WRY write in flight, or multiply result outstanding.
  typedef enum logic [1:0] {
    ST_IDLE  = YS_IDLE,
    ST_WRY_P = YS_WRY_P,
    ST_MUL_P = YS_MUL_P
  } yst_e;

  // True when exactly one bit is set. Callers zero-extend to 32 bits.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/sparc_exu_yctl_thr.sv
// One strand of the Y-register control: resolves the w > g > s priority for
// the 4:1 Y input mux and tracks whether this strand's Y has a pending write.
module sparc_exu_yctl_thr
  import sparc_exu_yctl_pkg::*;
(
  input  logic clk,
  input  logic arst_l,
  input  logic i_raw_w,      // registered WRY lands this cycle (W1)
  input  logic i_raw_g,      // multiplier result presented this cycle
  input  logic i_raw_s,      // MULScc step this cycle
  input  logic i_start_w,    // legal, non-killed WRY at W for this strand
  input  logic i_start_m,    // MUL issuing at E for this strand
  output logic o_wen_w,
  output logic o_wen_g,
  output logic o_wen_l,
  output logic o_shift_g,
  output logic o_busy,
  output logic o_err
);

  yst_e r_state;
  yst_e w_state_nxt;
  logic w_done;
  logic w_blocked;
  logic w_start_err;
  logic w_mask_err;

  // Fixed-priority one-hot select: WRY beats multiplier beats MULScc, else hold.
  always_comb begin
    o_wen_w   = i_raw_w;
    o_wen_g   = i_raw_g & ~i_raw_w;
    o_shift_g = i_raw_s & ~i_raw_w & ~i_raw_g;
    o_wen_l   = ~(o_wen_w | o_wen_g | o_shift_g);
  end

  // The pending write retires in the same cycle it reaches the Y mux, so a new
  // start in that cycle is accepted rather than flagged.
  assign w_done     = ((r_state == ST_WRY_P) & i_raw_w) |
                      ((r_state == ST_MUL_P) & o_wen_g);
  assign w_blocked  = (r_state != ST_IDLE) & ~w_done;
  assign w_mask_err = (i_raw_g & i_raw_w) | (i_raw_s & (i_raw_w | i_raw_g));

  // Next-state: retire completions first, then accept at most one new start.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_start_err = 1'b0;
    if (w_blocked) begin
      w_start_err = i_start_w | i_start_m;
    end else begin
      if (w_done) w_state_nxt = ST_IDLE;
      if (i_start_w) begin
        w_state_nxt = ST_WRY_P;
        w_start_err = i_start_m;
      end else if (i_start_m) begin
        w_state_nxt = ST_MUL_P;
      end
    end
  end

  // State register; reset abandons any pending write.
  always_ff @(posedge clk or negedge arst_l) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!arst_l) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  assign o_busy = (r_state != ST_IDLE) | i_start_w;
  assign o_err  = w_mask_err | w_start_err;

endmodule

// File: rtl/sparc_exu_div_yreg_ctl.sv
// Y-register control sequencer for the EXU divider: delays WRY into the W1
// cycle, qualifies thread selects, fans out to per-strand controllers and
// collects dropped-request / illegal-select errors.
module sparc_exu_div_yreg_ctl
  import sparc_exu_yctl_pkg::*;
#(
  parameter int NTHR       = NTHR_DEF,
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic            clk,
  input  logic            arst_l,
  input  logic            ecl_wry_vld_w,
  input  logic [NTHR-1:0] ecl_wry_thr_w,
  input  logic            ecl_wry_kill_w,
  input  logic            ecl_mul_start_e,
  input  logic [NTHR-1:0] ecl_mul_thr_e,
  input  logic            mul_yreg_vld_g,
  input  logic [NTHR-1:0] mul_yreg_thr_g,
  input  logic            ecl_mulscc_vld_g,
  input  logic [NTHR-1:0] ecl_mulscc_thr_g,
  output logic [NTHR-1:0] yctl_wen_w,
  output logic [NTHR-1:0] yctl_wen_g,
  output logic [NTHR-1:0] yctl_wen_l,
  output logic [NTHR-1:0] yctl_shift_g,
  output logic [NTHR-1:0] yctl_busy,
  output logic            yctl_err
);

  logic            w_ok_w, w_ok_m, w_ok_g, w_ok_s;
  logic            w_wry_go;
  logic            r_wry_w1;
  logic [NTHR-1:0] r_thr_w1;
  logic [NTHR-1:0] w_raw_w, w_raw_g, w_raw_s;
  logic [NTHR-1:0] w_start_w, w_start_m;
  logic [NTHR-1:0] w_thr_err;
  logic            w_sel_err;
  logic            w_err_now;

  // A non-one-hot select drops that request for every strand.
  assign w_ok_w = is_onehot(32'(ecl_wry_thr_w));
  assign w_ok_m = is_onehot(32'(ecl_mul_thr_e));
  assign w_ok_g = is_onehot(32'(mul_yreg_thr_g));
  assign w_ok_s = is_onehot(32'(ecl_mulscc_thr_g));

  assign w_wry_go  = ecl_wry_vld_w & ~ecl_wry_kill_w & w_ok_w;
  assign w_start_w = {NTHR{w_wry_go}} & ecl_wry_thr_w;
  assign w_start_m = {NTHR{ecl_mul_start_e & w_ok_m}} & ecl_mul_thr_e;
  assign w_raw_w   = {NTHR{r_wry_w1}} & r_thr_w1;
  assign w_raw_g   = {NTHR{mul_yreg_vld_g & w_ok_g}} & mul_yreg_thr_g;
  assign w_raw_s   = {NTHR{ecl_mulscc_vld_g & w_ok_s}} & ecl_mulscc_thr_g;

  // WRY pipe: aligns the write with the W->W1 data flop, one cycle after W.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      r_wry_w1 <= 1'b0;
      r_thr_w1 <= '0;
    end else begin
      r_wry_w1 <= w_wry_go;
      r_thr_w1 <= ecl_wry_thr_w;
    end
  end

  for (genvar t = 0; t < NTHR; t++) begin : g_thr
    sparc_exu_yctl_thr u_thr (
      .clk       (clk),
      .arst_l    (arst_l),
      .i_raw_w   (w_raw_w[t]),
      .i_raw_g   (w_raw_g[t]),
      .i_raw_s   (w_raw_s[t]),
      .i_start_w (w_start_w[t]),
      .i_start_m (w_start_m[t]),
      .o_wen_w   (yctl_wen_w[t]),
      .o_wen_g   (yctl_wen_g[t]),
      .o_wen_l   (yctl_wen_l[t]),
      .o_shift_g (yctl_shift_g[t]),
      .o_busy    (yctl_busy[t]),
      .o_err     (w_thr_err[t])
    );
  end

  assign w_sel_err = (ecl_wry_vld_w    & ~w_ok_w) |
                     (ecl_mul_start_e  & ~w_ok_m) |
                     (mul_yreg_vld_g   & ~w_ok_g) |
                     (ecl_mulscc_vld_g & ~w_ok_s);
  assign w_err_now = w_sel_err | (|w_thr_err);

  if (ERR_STICKY) begin : g_err_sticky
    logic r_err;
    // Sticky error flag: set by any error term, cleared only by reset.
    always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) r_err <= 1'b0;
      else         r_err <= r_err | w_err_now;
    end
    assign yctl_err = r_err;
  end else begin : g_err_pulse
    assign yctl_err = w_err_now;
  end

endmodule
